// File: rtl/window_absdiff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : window_absdiff_pipe
// Brief    : Computes |p_i - p_centre| for each tap of an NTAPS-pixel window.
//            Also produces the maximum tap difference and forwards the window
//            aligned with its results. Uses a 2-deep stallable valid/ready
//            pipeline, an activity gate and an accepted-window counter.
//            Optional macro THRESH_EN adds a per-tap threshold mask
//            (ports thresh / out_mask).
// Revision : 1.0 - initial release
// ============================================================================
module window_absdiff_pipe #(
  parameter int DW     = 8,
  parameter int NTAPS  = 9,
  parameter int CENTER = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act,
  input  logic                cnt_clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NTAPS*DW-1:0] in_win,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NTAPS*DW-1:0] out_diff,
  output logic [DW-1:0]       out_max,
  output logic [NTAPS*DW-1:0] out_win,
`ifdef THRESH_EN
  input  logic [DW-1:0]       thresh,
  output logic [NTAPS-1:0]    out_mask,
`endif
  output logic [CNT_W-1:0]    win_cnt
);

  logic                w_adv1;
  logic                w_adv2;
  logic                w_accept;
  logic [DW-1:0]       w_centre;
  logic [NTAPS*DW-1:0] w_diff;
  logic [DW-1:0]       w_max;

  logic                r_v1;
  logic                r_v2;
  logic [NTAPS*DW-1:0] r_s1_diff;
  logic [NTAPS*DW-1:0] r_s1_win;

  // A stage may take new data when it is empty or its successor moves on;
  // in_ready therefore ripples combinationally back from out_ready.
  assign w_adv2    = ~r_v2 | out_ready;
  assign w_adv1    = ~r_v1 | w_adv2;
  assign in_ready  = w_adv1;
  assign w_accept  = in_valid & w_adv1;
  assign out_valid = r_v2;

  assign w_centre = in_win[CENTER*DW +: DW];

  // Per-tap magnitude: one extra bit keeps the subtract exact, and the
  // magnitude of a difference of two DW-bit unsigned values fits in DW bits.
  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    logic signed [DW:0] w_sub;
    logic [DW-1:0]      w_mag;
    assign w_sub = $signed({1'b0, in_win[i*DW +: DW]}) - $signed({1'b0, w_centre});
    assign w_mag = w_sub[DW] ? (~w_sub[DW-1:0] + 1'b1) : w_sub[DW-1:0];
    // Inactive windows still travel, but carry zero differences.
    assign w_diff[i*DW +: DW] = act ? w_mag : '0;
  end

  // Unsigned maximum across the stage-1 differences.
  always_comb begin
    w_max = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (r_s1_diff[i*DW +: DW] > w_max) begin
        w_max = r_s1_diff[i*DW +: DW];
      end
    end
  end

  // Stage 1: capture differences and raw window whenever the stage advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1      <= 1'b0;
      r_s1_diff <= '0;
      r_s1_win  <= '0;
    end else if (w_adv1) begin
      r_v1      <= in_valid;
      r_s1_diff <= w_diff;
      r_s1_win  <= in_win;
    end
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2     <= 1'b0;
      out_diff <= '0;
      out_win  <= '0;
      out_max  <= '0;
    end else if (w_adv2) begin
      r_v2     <= r_v1;
      out_diff <= r_s1_diff;
      out_win  <= r_s1_win;
      out_max  <= w_max;
    end
  end

`ifdef THRESH_EN
  logic [NTAPS-1:0] w_mask;
  logic [NTAPS-1:0] r_s1_mask;

  for (genvar i = 0; i < NTAPS; i++) begin : g_mask
    assign w_mask[i] = (w_diff[i*DW +: DW] <= thresh);
  end

  // Threshold mask travels with the differences through both stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_mask <= '0;
      out_mask  <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_mask <= w_mask;
      end
      if (w_adv2) begin
        out_mask <= r_s1_mask;
      end
    end
  end
`endif

  // Accepted-window counter; a clear wins over a coincident accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
    end else if (cnt_clr) begin
      win_cnt <= '0;
    end else if (w_accept) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_absdiff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_absdiff_pipe
// Brief    : Directed self-checking bench for window_absdiff_pipe
//            (DW=8, NTAPS=9, CENTER=4, CNT_W=4). Threshold checks are
//            included when THRESH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_absdiff_pipe;

  localparam int DW    = 8;
  localparam int NT    = 9;
  localparam int CTR   = 4;
  localparam int CW    = 4;
  localparam int WW    = NT * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          act = 1'b1;
  logic          cnt_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_win = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_diff;
  logic [DW-1:0] out_max;
  logic [WW-1:0] out_win;
  logic [CW-1:0] win_cnt;
`ifdef THRESH_EN
  logic [DW-1:0] thresh = '0;
  logic [NT-1:0] out_mask;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  window_absdiff_pipe #(
    .DW(DW), .NTAPS(NT), .CENTER(CTR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .act(act), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_max(out_max), .out_win(out_win),
`ifdef THRESH_EN
    .thresh(thresh), .out_mask(out_mask),
`endif
    .win_cnt(win_cnt)
  );

  function automatic logic [WW-1:0] pk(input int t0, input int t1, input int t2,
                                       input int t3, input int t4, input int t5,
                                       input int t6, input int t7, input int t8);
    logic [WW-1:0] r;
    r[0*DW +: DW] = t0[7:0]; r[1*DW +: DW] = t1[7:0]; r[2*DW +: DW] = t2[7:0];
    r[3*DW +: DW] = t3[7:0]; r[4*DW +: DW] = t4[7:0]; r[5*DW +: DW] = t5[7:0];
    r[6*DW +: DW] = t6[7:0]; r[7*DW +: DW] = t7[7:0]; r[8*DW +: DW] = t8[7:0];
    return r;
  endfunction

  // Drive reset and idle inputs; returns 1 time unit after a rising edge.
  task automatic apply_reset();
    in_valid = 1'b0; cnt_clr = 1'b0; act = 1'b1; out_ready = 1'b1; in_win = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (win_cnt !== '0) begin n_bad++; $display("FAIL reset_win_cnt: got %0d want 0", win_cnt); end
    n_vec++; if (out_diff !== '0 || out_win !== '0 || out_max !== '0) begin
      n_bad++; $display("FAIL reset_data: diff %h win %h max %h want all 0", out_diff, out_win, out_max);
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [WW-1:0] w;
    apply_reset();
    w = pk(10, 20, 30, 40, 50, 60, 70, 80, 90);
    in_win = w; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1: out_valid got %b want 0", out_valid); end
    n_vec++; if (win_cnt !== 4'd1) begin n_bad++; $display("FAIL single_cnt: got %0d want 1", win_cnt); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat2: out_valid got %b want 1", out_valid); end
    n_vec++; if (out_diff !== pk(40, 30, 20, 10, 0, 10, 20, 30, 40)) begin
      n_bad++; $display("FAIL single_diff: got %h want %h", out_diff, pk(40, 30, 20, 10, 0, 10, 20, 30, 40));
    end
    n_vec++; if (out_max !== 8'd40) begin n_bad++; $display("FAIL single_max: got %0d want 40", out_max); end
    n_vec++; if (out_win !== w) begin n_bad++; $display("FAIL single_win: got %h want %h", out_win, w); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_bubble: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_extremes();
    logic [WW-1:0] e;
    apply_reset();
    e = pk(255, 255, 255, 255, 0, 255, 255, 255, 255);
    in_win = pk(0, 0, 0, 0, 255, 0, 0, 0, 0); in_valid = 1'b1;
    @(posedge clk); #1 in_win = pk(255, 255, 255, 255, 0, 255, 255, 255, 255);
    @(posedge clk); #1 in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_diff !== e || out_max !== 8'd255) begin
      n_bad++; $display("FAIL extreme_hi_ctr: valid %b diff %h max %0d want 1 %h 255", out_valid, out_diff, out_max, e);
    end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1 || out_diff !== e || out_max !== 8'd255) begin
      n_bad++; $display("FAIL extreme_lo_ctr: valid %b diff %h max %0d want 1 %h 255", out_valid, out_diff, out_max, e);
    end
  endtask

  task automatic test_act_gate();
    logic [WW-1:0] w;
    apply_reset();
    w = pk(5, 5, 5, 5, 100, 5, 5, 5, 5);
    in_win = w; in_valid = 1'b1; act = 1'b0;
    @(posedge clk); #1 act = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_diff !== '0 || out_max !== '0 || out_win !== w) begin
      n_bad++; $display("FAIL act_off: valid %b diff %h max %0d win %h want 1 0 0 %h", out_valid, out_diff, out_max, out_win, w);
    end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1 || out_diff !== pk(95, 95, 95, 95, 0, 95, 95, 95, 95) || out_max !== 8'd95) begin
      n_bad++; $display("FAIL act_on: valid %b diff %h max %0d want 1 %h 95", out_valid, out_diff, out_max,
                        pk(95, 95, 95, 95, 0, 95, 95, 95, 95));
    end
  endtask

  task automatic test_back_to_back();
    int sent, recv;
    logic held, saw_block, exp_rdy;
    logic [WW-1:0] hd_diff, hd_win;
    logic [DW-1:0] hd_max;
    apply_reset();
    sent = 0; recv = 0; held = 1'b0; saw_block = 1'b0;
    hd_diff = '0; hd_win = '0; hd_max = '0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      in_valid  = (sent < 6);
      in_win    = pk(0, 0, 0, 0, sent + 1, 0, 0, 0, 0);
      #1;
      exp_rdy = ((sent - recv) < 2) || out_ready;
      n_vec++; if (in_ready !== exp_rdy) begin
        n_bad++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (!in_ready) saw_block = 1'b1;
      if (held) begin
        n_vec++; if (out_valid !== 1'b1 || out_diff !== hd_diff || out_win !== hd_win || out_max !== hd_max) begin
          n_bad++; $display("FAIL bp_hold cyc %0d: valid %b win %h want 1 %h", cyc, out_valid, out_win, hd_win);
        end
      end
      if (sent == recv) begin
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_spurious cyc %0d: out_valid got %b want 0", cyc, out_valid); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (out_win !== pk(0, 0, 0, 0, recv + 1, 0, 0, 0, 0) ||
            out_diff !== pk(recv + 1, recv + 1, recv + 1, recv + 1, 0, recv + 1, recv + 1, recv + 1, recv + 1) ||
            out_max !== 8'(recv + 1)) begin
          n_bad++; $display("FAIL bp_beat %0d: win %h max %0d want centre %0d", recv, out_win, out_max, recv + 1);
        end
        recv++;
      end
      held = (out_valid === 1'b1) && !out_ready;
      hd_diff = out_diff; hd_win = out_win; hd_max = out_max;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (recv != 6 || sent != 6) begin n_bad++; $display("FAIL bp_count: recv %0d sent %0d want 6 6", recv, sent); end
    n_vec++; if (saw_block !== 1'b1) begin n_bad++; $display("FAIL bp_block: in_ready never dropped, got %b want 1", saw_block); end
    n_vec++; if (win_cnt !== 4'd6) begin n_bad++; $display("FAIL bp_win_cnt: got %0d want 6", win_cnt); end
  endtask

  task automatic test_counter();
    apply_reset();
    in_valid = 1'b1; in_win = pk(1, 2, 3, 4, 5, 6, 7, 8, 9);
    repeat (16) @(posedge clk);
    #1;
    n_vec++; if (win_cnt !== 4'd0) begin n_bad++; $display("FAIL cnt_wrap16: got %0d want 0", win_cnt); end
    @(posedge clk); #1;
    n_vec++; if (win_cnt !== 4'd1) begin n_bad++; $display("FAIL cnt_17: got %0d want 1", win_cnt); end
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    n_vec++; if (win_cnt !== 4'd0) begin n_bad++; $display("FAIL cnt_clr_prio: got %0d want 0", win_cnt); end
    @(posedge clk); #1 in_valid = 1'b0;
    n_vec++; if (win_cnt !== 4'd1) begin n_bad++; $display("FAIL cnt_after_clr: got %0d want 1", win_cnt); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_stall();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_win = pk(10, 20, 30, 40, 50, 60, 70, 80, 90);
`ifdef THRESH_EN
    thresh = 8'd15;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_full: in_ready %b out_valid %b want 0 1", in_ready, out_valid);
    end
`ifdef THRESH_EN
    n_vec++; if (out_mask !== 9'b000111000) begin n_bad++; $display("FAIL thresh_mask: got %b want 000111000", out_mask); end
`endif
    #2 rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || win_cnt !== '0 || out_win !== '0 || out_diff !== '0) begin
      n_bad++; $display("FAIL stall_async_rst: valid %b ready %b cnt %0d win %h", out_valid, in_ready, win_cnt, out_win);
    end
`ifdef THRESH_EN
    n_vec++; if (out_mask !== '0) begin n_bad++; $display("FAIL stall_rst_mask: got %b want 0", out_mask); end
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_release: ready %b valid %b want 1 0", in_ready, out_valid);
    end
  endtask

`ifdef THRESH_EN
  task automatic test_thresh();
    apply_reset();
    thresh = 8'd15; in_valid = 1'b1; in_win = pk(10, 20, 30, 40, 50, 60, 70, 80, 90);
    @(posedge clk); #1 in_valid = 1'b0; thresh = 8'd0;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1 || out_mask !== 9'b000111000) begin
      n_bad++; $display("FAIL thresh_flow: valid %b mask %b want 1 000111000", out_valid, out_mask);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_act_gate();
    test_back_to_back();
    test_counter();
`ifdef THRESH_EN
    test_thresh();
`endif
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_absdiff_pipe.md
Name: window_absdiff_pipe

Overview:
- Parametrised successor to the first filter stage. Takes an NTAPS-pixel neighbourhood window and computes |p_i - p_centre| for every tap.
- Also produces the maximum tap difference and forwards the window aligned with its results.
- Adds valid/ready flow control, a 2-deep stallable pipeline, an activity gate and an accepted-window counter.
- Sits between the line-buffer/window generator and the weighting stage.

Parameters:
- DW, 8, pixel width in bits.
- NTAPS, 9, number of window taps (3..25).
- CENTER, 4, index of the centre tap (0..NTAPS-1).
- CNT_W, 16, width of the accepted-window counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- act  in  1  compute enable; sampled with each accepted window.
- cnt_clr  in  1  synchronous clear of win_cnt.
- in_valid  in  1  input window valid.
- in_ready  out  1  block can accept a window this cycle.
- in_win  in  NTAPS*DW  window; tap i at bits [i*DW +: DW].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_diff  out  NTAPS*DW  absolute differences; tap i at [i*DW +: DW].
- out_max  out  DW  maximum of all out_diff taps.
- out_win  out  NTAPS*DW  window delayed to align with out_diff.
- win_cnt  out  CNT_W  number of accepted windows, modulo 2^CNT_W.

Behaviour:
- Reset (rst low, asynchronous): the following all go to 0 immediately, and any in-flight beats are discarded.
  - Stage valids v1 and v2.
  - out_diff, out_max, out_win, win_cnt.
- Pipeline stages:
  - S1 registers diff_i = |in_win[i] - in_win[CENTER]| using DW+1-bit signed subtract then magnitude. The result always fits in DW bits. It also registers the raw window and v1.
  - S2 registers out_diff = S1 diffs and out_win = S1 window. out_max is the unsigned maximum over all NTAPS S1 diffs; on ties the value is identical, so no index is needed. It also registers v2, which drives out_valid.
- Centre tap: diff is always 0.
- act gate: if act=0 on the accepting cycle, all S1 diffs are registered as 0. The window still propagates, so out_win stays valid data and out_max = 0.
- Advance rules:
  - adv2 = ~v2 | out_ready.
  - adv1 = ~v1 | adv2.
  - in_ready = adv1; this is a combinational path from out_ready.
  - S1 loads when adv1 is high: v1 <= in_valid. S2 loads when adv2 is high: v2 <= v1.
  - Stages that do not advance hold data and valid unchanged.
- Latency: 2 cycles from accept (in_valid & in_ready) to out_valid, with out_ready held high.
- Throughput: 1 window per cycle.
- Stall: out_valid and out_* hold stable while out_valid=1 and out_ready=0.
  - The pipeline absorbs at most 2 beats, then in_ready=0.
  - Data is never dropped or duplicated.
- Bubbles: with a gap in in_valid, v1=0 propagates as a bubble and out_valid goes low for that slot. Output data registers may hold stale values when out_valid=0.
- Counter:
  - win_cnt increments on each accept and wraps from 2^CNT_W-1 to 0.
  - cnt_clr=1 forces win_cnt to 0 the next cycle. It takes priority over a simultaneous accept; that accept is not counted.
- Boundaries:
  - Full diff range: inputs 0 and 2^DW-1 give diff 2^DW-1.
  - Reset mid-stall: all valids clear; on release, in_ready=1 on the first cycle.

Optional Feature:
- Macro THRESH_EN.
- When defined, adds two ports:
  - thresh, input, DW bits.
  - out_mask, output, NTAPS bits.
- out_mask[i] = 1 when the S1 diff_i <= thresh, with thresh sampled at S1 load. The mask is registered in S2 alongside out_diff, resets to 0, and obeys the same hold/stall rules.
- Centre tap mask bit is therefore 1.
- When not defined, neither port exists and there is no threshold logic.

Test Plan:
- Reset release, single window:
  - Stimulus: DW=8, taps [10,20,30,40,50,60,70,80,90], act=1, out_ready=1.
  - Required: out_valid 2 cycles after accept; out_diff=[40,30,20,10,0,10,20,30,40]; out_max=40; out_win equals input; win_cnt=1.
- Extremes:
  - Stimulus: centre=255, all other taps 0, then centre=0 with other taps 255.
  - Required: every non-centre diff=255, out_max=255, centre diff=0 in both beats.
- Backpressure:
  - Stimulus: stream 6 windows (centre values 1..6) back-to-back; hold out_ready=0 for cycles 3-7, then release.
  - Required: in_ready drops after 2 beats are buffered; outputs hold stable while stalled; all 6 beats emerge in order, none lost or duplicated; win_cnt=6.
- act gate:
  - Stimulus: window [5,5,5,5,100,5,5,5,5] with act=0, then the same window with act=1.
  - Required: first beat out_diff all 0 and out_max=0, with out_win intact; second beat diffs 95 except centre 0, out_max=95.
- Counter:
  - Stimulus: CNT_W=4, 17 accepts; then cnt_clr asserted on the same cycle as an accept.
  - Required: win_cnt=1 after the 17 accepts (wrap); after the simultaneous clr and accept, win_cnt=0.
- THRESH_EN build:
  - Stimulus: thresh=15, window [10,20,30,40,50,60,70,80,90].
  - Required: out_mask bit i = 1 only for taps 3, 4 and 5, i.e. out_mask=9'b000111000.
  - Also: an async reset while stalled clears out_valid and out_mask immediately.
